lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, data-memory byte-address width.
REQ-002 Parameter RD_W, 5, destination-register index width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  pipeline presents a memory operation.
REQ-006 req_ready_o  output  1  controller accepts the operation this cycle.
REQ-007 mem_op_i  input  MEM_OP_BITS  core::mem_op_t (LB/LH/LW/LBU/LHU/SB/SH/SW/MEM_NOP).
REQ-008 addr_i  input  ADDR_W  byte address; wdata_i  input  32  store data; rd_i  input  RD_W  load destination.
REQ-009 dmem_req_o  output  1  memory request; dmem_gnt_i  input  1  request accepted.
REQ-010 dmem_addr_o  output  ADDR_W  word-aligned address (bits[1:0]=0); dmem_we_o  output  1; dmem_be_o  output  4; dmem_wdata_o  output  32.
REQ-011 dmem_rvalid_i  input  1  read data valid; dmem_rdata_i  input  32.
REQ-012 rsp_valid_o  output  1  completion strobe; rsp_data_o  output  32  extended load data (0 for stores); rsp_rd_o  output  RD_W; rsp_err_o  output  1  misaligned-access error.
REQ-013 stall_o  output  1  pipeline must hold; equals controller busy (state != IDLE).

Function
REQ-014 The FSM SHALL use the states IDLE, REQ0, WAIT0, REQ1, WAIT1 and RESP.
REQ-015 req_ready_o SHALL be 1 only in IDLE; an operation is accepted when req_valid_i & req_ready_o, and op, addr, wdata and rd are registered.
REQ-016 An accepted MEM_NOP SHALL go to RESP with no dmem access; its rsp_data_o is 0.
REQ-017 An accepted memory op SHALL go to REQ0: dmem_req_o=1 with address, we, be and wdata held stable until dmem_gnt_i; gnt is permitted in the same cycle as req.
REQ-018 Byte enables SHALL be: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111<<off, truncated to 4 bits (off=addr[1:0]); wdata is shifted left by off*8.
REQ-019 A store SHALL complete on gnt of its last beat, then go to RESP; loads go REQn->WAITn on gnt and leave WAITn on dmem_rvalid_i.
REQ-020 A beat is split when the access crosses a word boundary (LH/LHU/SH off=3; LW/SW off!=0).
REQ-021 Beat 1 SHALL use addr+4 (word-aligned), be = (full_be>>4), and wdata >> ((4-off)*8).
REQ-022 Load data SHALL be formed as ({beat1,beat0} >> off*8)[size-1:0]. LB/LH sign-extend; LBU/LHU/LW zero-extend.
REQ-023 rsp_valid_o SHALL be high for exactly one cycle in RESP, then return to IDLE; the latency for an aligned load with gnt in REQ0 and rvalid on the next cycle is 3 cycles from acceptance.
REQ-024 Only one memory transaction SHALL be outstanding; dmem_rvalid_i outside WAIT0/WAIT1 SHALL be ignored.
REQ-025 rsp_rd_o SHALL equal the registered rd for loads and 0 for stores and NOP.

Reset
REQ-026 On rst_ni=0, state SHALL go asynchronously to IDLE and all outputs to 0, except req_ready_o, which goes to 1.
REQ-027 Reset mid-transaction SHALL abandon it: no rsp_valid_o, and a later stray rvalid is ignored (REQ-024).

Configuration
REQ-028 With LSU_MISALIGN_SPLIT_EN defined, crossing accesses are split per REQ-020..022.
REQ-029 Without LSU_MISALIGN_SPLIT_EN, crossing accesses SHALL issue no dmem request and go directly to RESP with rsp_err_o=1 and rsp_data_o=0; REQ1/WAIT1 are not implemented.

Structure
REQ-030 The lsu_state_t enum and the size/sign helper constants for mem_op_t SHALL live in package core.
REQ-031 Combinational shift, select and extension SHALL live in sub-module lsu_rdata_align (inputs: op, off, beat0, beat1; output: 32-bit data); lsu_ctrl holds the FSM and registers only.

Verification
REQ-032 LW at 0x100, gnt in the same cycle, rdata 0xDEADBEEF the next cycle -> rsp_data_o 0xDEADBEEF, rsp_valid_o 3 cycles after acceptance, stall_o high meanwhile.
REQ-033 LB at 0x103 with rdata 0x80000000 -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-034 SH at 0x202 with wdata 0x1234ABCD -> dmem_be_o 4'b1100, dmem_wdata_o 0xABCD0000, dmem_addr_o 0x200, we=1.
REQ-035 Split enabled: LW at 0x301 with beats 0x44332211 and 0x88776655 -> two requests, to 0x300 and 0x304, rsp_data_o 0x55443322. Split disabled: rsp_err_o=1 and no dmem_req_o.
REQ-036 gnt withheld 5 cycles -> request signals stable throughout. Reset asserted in WAIT0, then rvalid after release -> no rsp_valid_o, and req_ready_o=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared LSU types: memory-op encoding, controller state, size/sign helpers.
package core;

    localparam int MEM_OP_BITS = 4;

    typedef enum logic [MEM_OP_BITS-1:0] {
        MEM_NOP = 4'd0,
        LB      = 4'd1,
        LH      = 4'd2,
        LW      = 4'd3,
        LBU     = 4'd4,
        LHU     = 4'd5,
        SB      = 4'd6,
        SH      = 4'd7,
        SW      = 4'd8
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

    localparam logic [2:0] SZ_NONE = 3'd0;
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB: op_size = SZ_BYTE;
            LH, LHU, SH: op_size = SZ_HALF;
            LW, SW:      op_size = SZ_WORD;
            default:     op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_signed(input mem_op_t op);
        op_signed = (op == LB) || (op == LH);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        op_is_store = (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic op_is_load(input mem_op_t op);
        op_is_load = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    // True when the access spills past the end of its 32-bit word.
    function automatic logic op_crosses(input mem_op_t op, input logic [1:0] off);
        op_crosses = ((op_size(op) == SZ_HALF) && (off == 2'd3)) ||
                     ((op_size(op) == SZ_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Load-data alignment: shifts the two-beat window by the byte offset, selects, extends.
module lsu_rdata_align
    import core::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic        sext;

    assign shifted = 32'({beat1, beat0} >> {off, 3'b000});
    assign sext    = op_signed(op);

    always_comb begin
        data = shifted;
        case (op_size(op))
            SZ_BYTE: data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding dmem transaction, optional two-beat split.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they fault.
module lsu_ctrl
    import core::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  mem_op_t           mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic [RD_W-1:0]   rsp_rd_o,
    output logic              rsp_err_o,
    output logic              stall_o
);

    lsu_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [31:0]       beat0_q, beat0_d;
    logic [31:0]       beat1_q, beat1_d;
    logic              err_q, err_d;

    logic [3:0]        base_be;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;
    logic [ADDR_W-1:0] word_addr;
    logic              beat_hi;
    logic [31:0]       load_data;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic crosses_q;
    assign crosses_q = op_crosses(op_q, addr_q[1:0]);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = mem_op_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    rd_d    = rd_i;
                    err_d   = 1'b0;
                    if (mem_op_i == MEM_NOP) begin
                        state_d = RESP;
                    end else begin
                        state_d = REQ0;
`ifndef LSU_MISALIGN_SPLIT_EN
                        if (op_crosses(mem_op_i, addr_i[1:0])) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
`endif
                    end
                end
            end
            REQ0: begin
                if (dmem_gnt_i) begin
                    if (!op_is_store(op_q)) state_d = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (crosses_q)     state_d = REQ1;
`endif
                    else                    state_d = RESP;
                end
            end
            WAIT0: begin
                if (dmem_rvalid_i) begin
                    beat0_d = dmem_rdata_i;
                    state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (crosses_q) state_d = REQ1;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1: begin
                if (dmem_gnt_i) state_d = op_is_store(op_q) ? RESP : WAIT1;
            end
            WAIT1: begin
                if (dmem_rvalid_i) begin
                    beat1_d = dmem_rdata_i;
                    state_d = RESP;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (op_size(op_q))
            SZ_BYTE: base_be = 4'b0001;
            SZ_HALF: base_be = 4'b0011;
            default: base_be = 4'b1111;
        endcase
    end

    // Upper halves of the widened enables/data feed the second beat.
    assign be_wide    = {4'b0000, base_be} << addr_q[1:0];
    assign wdata_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign beat_hi    = (state_q == REQ1);

    lsu_rdata_align u_align (
        .op    (op_q),
        .off   (addr_q[1:0]),
        .beat0 (beat0_q),
        .beat1 (beat1_q),
        .data  (load_data)
    );

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        stall_o      = (state_q != IDLE);
        dmem_req_o   = (state_q == REQ0) || (state_q == REQ1);
        dmem_addr_o  = '0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        if (dmem_req_o) begin
            dmem_addr_o  = beat_hi ? (word_addr + ADDR_W'(4)) : word_addr;
            dmem_we_o    = op_is_store(op_q);
            dmem_be_o    = beat_hi ? be_wide[7:4] : be_wide[3:0];
            dmem_wdata_o = beat_hi ? wdata_wide[63:32] : wdata_wide[31:0];
        end
        rsp_valid_o = (state_q == RESP);
        rsp_err_o   = rsp_valid_o & err_q;
        rsp_data_o  = (rsp_valid_o && op_is_load(op_q) && !err_q) ? load_data : '0;
        rsp_rd_o    = (rsp_valid_o && op_is_load(op_q)) ? rd_q : '0;
    end

endmodule
